// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - constants, FSM encoding and chip entry type shared by rx_seq_reader
package rx_pkg;

  localparam int RX_SEQ_LEN = 255;
  localparam int RX_ADDR_W  = 8;
  localparam int RX_DATA_W  = 16;
  localparam int RX_SEL_W   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic                 chip;
    logic [RX_ADDR_W-1:0] idx;
    logic                 last;
  } rx_chip_t;

  // Sequence k lives in bit (DATA_W-1-k) of every word.
  function automatic logic [RX_SEL_W-1:0] rx_col(input logic [RX_SEL_W-1:0] sel);
    return RX_SEL_W'(RX_DATA_W - 1) - sel;
  endfunction

endpackage

// File: rtl/rx_chip_skid.sv
// rtl/rx_chip_skid.sv - 2-entry valid/ready FIFO with occupancy count
module rx_chip_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid_i,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         pop;

  assign pop_valid_o = (count_q != 2'd0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign pop         = pop_valid_o & pop_ready_i;

  always_comb begin
    count_d = count_q + 2'(push_valid_i) - 2'(pop);
  end

  // The producer never pushes while full, so no overflow guard is needed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_valid_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_seq_reader.sv
// rtl/rx_seq_reader.sv - streams one BRAM column chip by chip; RX_SEQ_LOOP_EN adds looping
module rx_seq_reader
  import rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RX_SEL_W-1:0]  seq_sel,
`ifdef RX_SEQ_LOOP_EN
  input  logic                 loop,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 bram_enb,
  output logic [RX_ADDR_W-1:0] bram_addrb,
  input  logic [RX_DATA_W-1:0] bram_dob,
  output logic                 chip_data,
  output logic                 chip_valid,
  input  logic                 chip_ready,
  output logic                 chip_last,
  output logic [RX_ADDR_W-1:0] chip_idx
);

  logic [1:0]           state_q, state_d;
  logic [RX_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [RX_SEL_W-1:0]  sel_q, sel_d;
  logic                 inflight_q;
  logic [RX_ADDR_W-1:0] inf_idx_q;
  logic                 inf_last_q;
  logic [1:0]           buf_count;
  logic [2:0]           occupancy;
  logic                 pop, issue, at_end, wrap;
  rx_chip_t             push_entry, head;

  assign pop       = chip_valid & chip_ready;
  // Reads are only issued when the returning word is guaranteed a free slot.
  assign occupancy = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == ST_FETCH) && (occupancy < 3'd2);
  assign at_end    = (rd_addr_q == RX_ADDR_W'(RX_SEQ_LEN - 1));

`ifdef RX_SEQ_LOOP_EN
  assign wrap = loop;
`else
  assign wrap = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    sel_d     = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d     = seq_sel;
          rd_addr_d = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          if (at_end) begin
            rd_addr_d = '0;
            if (!wrap) state_d = ST_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + RX_ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      sel_q      <= '0;
      inflight_q <= 1'b0;
      inf_idx_q  <= '0;
      inf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      sel_q      <= sel_d;
      inflight_q <= issue;
      inf_idx_q  <= rd_addr_q;
      inf_last_q <= at_end;
    end
  end

  assign push_entry = {bram_dob[rx_col(sel_q)], inf_idx_q, inf_last_q};

  rx_chip_skid #(
    .W($bits(rx_chip_t))
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (inflight_q),
    .push_data_i  (push_entry),
    .pop_valid_o  (chip_valid),
    .pop_ready_i  (chip_ready),
    .pop_data_o   (head),
    .count_o      (buf_count)
  );

  assign chip_data  = head.chip;
  assign chip_idx   = head.idx;
  assign chip_last  = head.last;
  assign busy       = (state_q != ST_IDLE);
  // Earlier loop periods finish in FETCH, so only the final period's last chip lands here.
  assign done       = (state_q == ST_DRAIN) & pop & head.last;
  assign bram_enb   = issue;
  assign bram_addrb = rd_addr_q;

endmodule
